// File: rtl/kfx86_shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: drives a single-bit shift ALU once per clock
// and feeds its result and flags back until the count is used up.

package kfx86_shift_pkg;
    typedef struct packed {
        logic of;
        logic sf;
        logic zf;
        logic af;
        logic pf;
        logic cf;
    } flags_t;

    localparam logic [4:0] ALU_OP_ADD = 5'd0;
    localparam logic [4:0] ALU_OP_OR  = 5'd1;
    localparam logic [4:0] ALU_OP_ADC = 5'd2;
    localparam logic [4:0] ALU_OP_SBB = 5'd3;
    localparam logic [4:0] ALU_OP_AND = 5'd4;
    localparam logic [4:0] ALU_OP_SUB = 5'd5;
    localparam logic [4:0] ALU_OP_XOR = 5'd6;
    localparam logic [4:0] ALU_OP_CMP = 5'd7;
    localparam logic [4:0] ALU_OP_ROL = 5'd8;
    localparam logic [4:0] ALU_OP_ROR = 5'd9;
    localparam logic [4:0] ALU_OP_RCL = 5'd10;
    localparam logic [4:0] ALU_OP_RCR = 5'd11;
    localparam logic [4:0] ALU_OP_SHL = 5'd12;
    localparam logic [4:0] ALU_OP_SHR = 5'd13;
    localparam logic [4:0] ALU_OP_SAR = 5'd15;
endpackage

module kfx86_shift_sequencer
    import kfx86_shift_pkg::*;
#(
    parameter bit MASK_COUNT = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic        select_word,
    input  logic [15:0] operand,
    input  logic [7:0]  count,
    input  flags_t      flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output flags_t      result_flags,
    output logic [4:0]  alu_opcode,
    output logic [15:0] alu_source_1,
    output logic [15:0] alu_source_2,
    output flags_t      alu_source_flags,
    output logic        alu_select_word,
    input  logic [15:0] alu_out,
    input  flags_t      alu_out_flags
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      state_reg;
    logic [4:0]  opcode_reg;
    logic        word_reg;
    logic [15:0] work_reg;
    flags_t      flags_reg;
    logic [7:0]  remaining_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] result_reg;
    flags_t      result_flags_reg;

    logic [7:0]  eff_count;
    logic        is_shift;

    always_comb begin
        eff_count = MASK_COUNT ? {3'b000, count[4:0]} : count;
    end

    always_comb begin
        case (opcode)
            ALU_OP_ROL, ALU_OP_ROR, ALU_OP_RCL, ALU_OP_RCR,
            ALU_OP_SHL, ALU_OP_SHR, ALU_OP_SAR: is_shift = 1'b1;
            default:                            is_shift = 1'b0;
        endcase
    end

    // Result registers are loaded on entry to DONE so they are valid during the done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            opcode_reg       <= '0;
            word_reg         <= 1'b0;
            work_reg         <= '0;
            flags_reg        <= '0;
            remaining_reg    <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            result_reg       <= '0;
            result_flags_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        opcode_reg <= opcode;
                        word_reg   <= select_word;
                        work_reg   <= operand;
                        flags_reg  <= flags_in;
                        busy_reg   <= 1'b1;
                        if (!is_shift || eff_count == 8'd0) begin
                            state_reg        <= ST_DONE;
                            done_reg         <= 1'b1;
                            remaining_reg    <= '0;
                            result_reg       <= operand;
                            result_flags_reg <= flags_in;
                        end else begin
                            state_reg     <= ST_RUN;
                            remaining_reg <= eff_count;
                        end
                    end
                end
                ST_RUN: begin
                    work_reg      <= alu_out;
                    flags_reg     <= alu_out_flags;
                    remaining_reg <= remaining_reg - 8'd1;
                    if (remaining_reg == 8'd1) begin
                        state_reg        <= ST_DONE;
                        done_reg         <= 1'b1;
                        result_reg       <= alu_out;
                        result_flags_reg <= alu_out_flags;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_reg;
    assign done             = done_reg;
    assign result           = result_reg;
    assign result_flags     = result_flags_reg;
    assign alu_opcode       = opcode_reg;
    assign alu_source_1     = work_reg;
    assign alu_source_2     = 16'h0000;
    assign alu_source_flags = flags_reg;
    assign alu_select_word  = word_reg;

endmodule

// File: tb/tb_kfx86_shift_sequencer.sv
// Directed bench for kfx86_shift_sequencer with a behavioural single-bit shift ALU;
// one instance uses the full 8-bit count, the other masks it to 5 bits.

module tb_kfx86_shift_sequencer;
    import kfx86_shift_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [4:0]  opcode = '0;
    logic        select_word = 1'b0;
    logic [15:0] operand = '0;
    logic [7:0]  count = '0;
    flags_t      flags_in = '0;

    logic        busy0, done0, alu_select_word0;
    logic [15:0] result0, alu_source_10, alu_source_20, alu_out0;
    logic [4:0]  alu_opcode0;
    flags_t      result_flags0, alu_source_flags0, alu_out_flags0;
    logic [21:0] alu_res0;

    logic        busy1, done1, alu_select_word1;
    logic [15:0] result1, alu_source_11, alu_source_21, alu_out1;
    logic [4:0]  alu_opcode1;
    flags_t      result_flags1, alu_source_flags1, alu_out_flags1;
    logic [21:0] alu_res1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    // Single-bit x86 shift/rotate: rotates keep SF/ZF/PF, shifts recompute them.
    function automatic logic [21:0] alu_model(input logic [4:0] op, input logic [15:0] a,
                                              input flags_t f, input logic w);
        logic [15:0] r;
        flags_t      o;
        logic        msb, rm, rm1;
        o   = f;
        r   = a;
        msb = w ? a[15] : a[7];
        case (op)
            ALU_OP_ROL: begin r = w ? {a[14:0], a[15]} : {8'h00, a[6:0], a[7]}; o.cf = msb; end
            ALU_OP_ROR: begin r = w ? {a[0], a[15:1]} : {8'h00, a[0], a[7:1]}; o.cf = a[0]; end
            ALU_OP_RCL: begin r = w ? {a[14:0], f.cf} : {8'h00, a[6:0], f.cf}; o.cf = msb; end
            ALU_OP_RCR: begin r = w ? {f.cf, a[15:1]} : {8'h00, f.cf, a[7:1]}; o.cf = a[0]; end
            ALU_OP_SHL: begin r = w ? {a[14:0], 1'b0} : {8'h00, a[6:0], 1'b0}; o.cf = msb; end
            ALU_OP_SHR: begin r = w ? {1'b0, a[15:1]} : {8'h00, 1'b0, a[7:1]}; o.cf = a[0]; end
            ALU_OP_SAR: begin r = w ? {a[15], a[15:1]} : {8'h00, a[7], a[7:1]}; o.cf = a[0]; end
            default:    r = a;
        endcase
        rm  = w ? r[15] : r[7];
        rm1 = w ? r[14] : r[6];
        case (op)
            ALU_OP_ROL, ALU_OP_RCL, ALU_OP_SHL: o.of = rm ^ o.cf;
            ALU_OP_ROR, ALU_OP_RCR:             o.of = rm ^ rm1;
            ALU_OP_SHR:                         o.of = msb;
            ALU_OP_SAR:                         o.of = 1'b0;
            default:                            o.of = f.of;
        endcase
        if (op == ALU_OP_SHL || op == ALU_OP_SHR || op == ALU_OP_SAR) begin
            o.sf = rm;
            o.zf = w ? (r == 16'h0000) : (r[7:0] == 8'h00);
            o.pf = ~^r[7:0];
        end
        return {r, o};
    endfunction

    always_comb alu_res0 = alu_model(alu_opcode0, alu_source_10, alu_source_flags0, alu_select_word0);
    always_comb alu_res1 = alu_model(alu_opcode1, alu_source_11, alu_source_flags1, alu_select_word1);
    assign alu_out0       = alu_res0[21:6];
    assign alu_out_flags0 = flags_t'(alu_res0[5:0]);
    assign alu_out1       = alu_res1[21:6];
    assign alu_out_flags1 = flags_t'(alu_res1[5:0]);

    kfx86_shift_sequencer #(.MASK_COUNT(1'b0)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .opcode(opcode),
        .select_word(select_word), .operand(operand), .count(count), .flags_in(flags_in),
        .busy(busy0), .done(done0), .result(result0), .result_flags(result_flags0),
        .alu_opcode(alu_opcode0), .alu_source_1(alu_source_10), .alu_source_2(alu_source_20),
        .alu_source_flags(alu_source_flags0), .alu_select_word(alu_select_word0),
        .alu_out(alu_out0), .alu_out_flags(alu_out_flags0)
    );

    kfx86_shift_sequencer #(.MASK_COUNT(1'b1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .opcode(opcode),
        .select_word(select_word), .operand(operand), .count(count), .flags_in(flags_in),
        .busy(busy1), .done(done1), .result(result1), .result_flags(result_flags1),
        .alu_opcode(alu_opcode1), .alu_source_1(alu_source_11), .alu_source_2(alu_source_21),
        .alu_source_flags(alu_source_flags1), .alu_select_word(alu_select_word1),
        .alu_out(alu_out1), .alu_out_flags(alu_out_flags1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one instruction and reports latency (cycle index of done), busy-cycle count,
    // the held result, and busy one cycle after done.
    task automatic run_op(input bit sel, input logic [4:0] op, input logic w,
                          input logic [15:0] val, input logic [7:0] cnt, input flags_t f,
                          output int lat, output int busy_cnt, output logic [15:0] res,
                          output flags_t rf, output logic busy_after);
        @(negedge clock);
        opcode = op; select_word = w; operand = val; count = cnt; flags_in = f;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clock); #1;
        start0 = 1'b0; start1 = 1'b0;
        opcode = ALU_OP_ROR; operand = 16'hA5A5; count = 8'h03; flags_in = '1; select_word = ~w;
        lat = 1;
        busy_cnt = 0;
        while ((sel ? done1 : done0) !== 1'b1 && lat < 400) begin
            if ((sel ? busy1 : busy0) === 1'b1) busy_cnt++;
            @(posedge clock); #1;
            lat++;
        end
        if ((sel ? busy1 : busy0) === 1'b1) busy_cnt++;
        res = sel ? result1 : result0;
        rf  = sel ? result_flags1 : result_flags0;
        @(posedge clock); #1;
        busy_after = sel ? busy1 : busy0;
        $display("op=%0d word=%0b cnt=%0d dut%0d: latency=%0d result=0x%04h flags=0x%02h",
                 op, w, cnt, sel, lat, res, rf);
    endtask

    initial begin
        int          lat, bc;
        logic [15:0] res;
        flags_t      rf;
        logic        ba;

        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", {31'b0, busy0}, 32'd0);
        check("reset_done", {31'b0, done0}, 32'd0);
        check("reset_result", {16'b0, result0}, 32'd0);
        check("reset_flags", {26'b0, result_flags0}, 32'd0);
        reset = 1'b0;

        run_op(1'b0, ALU_OP_SHL, 1'b0, 16'h0081, 8'd1, flags_t'(6'b000000), lat, bc, res, rf, ba);
        check("shl_latency", lat, 32'd2);
        check("shl_result", {16'b0, res}, 32'h0002);
        check("shl_flags", {26'b0, rf}, {26'b0, 6'b100001});

        run_op(1'b0, ALU_OP_ROL, 1'b1, 16'h8001, 8'd4, flags_t'(6'b000000), lat, bc, res, rf, ba);
        check("rol_latency", lat, 32'd5);
        check("rol_busy_cycles", bc, 32'd5);
        check("rol_busy_after", {31'b0, ba}, 32'd0);
        check("rol_result", {16'b0, res}, 32'h0018);
        check("rol_flags", {26'b0, rf}, 32'd0);

        run_op(1'b0, ALU_OP_RCR, 1'b0, 16'h0001, 8'd9, flags_t'(6'b000000), lat, bc, res, rf, ba);
        check("rcr9_latency", lat, 32'd10);
        check("rcr9_result", {16'b0, res}, 32'h0001);
        check("rcr9_flags", {26'b0, rf}, 32'd0);

        run_op(1'b0, ALU_OP_RCL, 1'b0, 16'h0080, 8'd1, flags_t'(6'b000000), lat, bc, res, rf, ba);
        check("rcl_result", {16'b0, res}, 32'h0000);
        check("rcl_flags", {26'b0, rf}, {26'b0, 6'b100001});

        run_op(1'b0, ALU_OP_SAR, 1'b0, 16'h0080, 8'd255, flags_t'(6'b000000), lat, bc, res, rf, ba);
        check("sar255_latency", lat, 32'd256);
        check("sar255_result", {16'b0, res}, 32'h00FF);
        check("sar255_flags", {26'b0, rf}, {26'b0, 6'b010011});

        run_op(1'b1, ALU_OP_SAR, 1'b0, 16'h0080, 8'd255, flags_t'(6'b000000), lat, bc, res, rf, ba);
        check("sar_masked_latency", lat, 32'd32);
        check("sar_masked_result", {16'b0, res}, 32'h00FF);
        check("sar_masked_flags", {26'b0, rf}, {26'b0, 6'b010011});

        run_op(1'b0, ALU_OP_SHL, 1'b1, 16'h1234, 8'd0, flags_t'(6'b101010), lat, bc, res, rf, ba);
        check("cnt0_latency", lat, 32'd1);
        check("cnt0_result", {16'b0, res}, 32'h1234);
        check("cnt0_flags", {26'b0, rf}, {26'b0, 6'b101010});

        run_op(1'b0, ALU_OP_ADD, 1'b1, 16'h1234, 8'd5, flags_t'(6'b010101), lat, bc, res, rf, ba);
        check("add_latency", lat, 32'd1);
        check("add_result", {16'b0, res}, 32'h1234);
        check("add_flags", {26'b0, rf}, {26'b0, 6'b010101});

        // Abort sequence: a long SHR, an ignored second start, then reset mid-run.
        @(negedge clock);
        opcode = ALU_OP_SHR; select_word = 1'b1; operand = 16'hFFFF; count = 8'd10;
        flags_in = '0; start0 = 1'b1;
        @(posedge clock); #1;
        start0 = 1'b0;
        check("abort_busy_c1", {31'b0, busy0}, 32'd1);
        @(posedge clock); #1;
        operand = 16'h0001; count = 8'd1; start0 = 1'b1;
        @(posedge clock); #1;
        start0 = 1'b0;
        check("abort_busy_c3", {31'b0, busy0}, 32'd1);
        check("abort_done_c3", {31'b0, done0}, 32'd0);
        @(posedge clock); #1;
        check("abort_held_result", {16'b0, result0}, 32'h1234);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_busy", {31'b0, busy0}, 32'd0);
        check("abort_done", {31'b0, done0}, 32'd0);
        check("abort_result", {16'b0, result0}, 32'd0);
        check("abort_flags", {26'b0, result_flags0}, 32'd0);
        $display("reset mid-run: busy=%0b done=%0b result=0x%04h", busy0, done0, result0);

        run_op(1'b0, ALU_OP_SHR, 1'b1, 16'hFFFF, 8'd10, flags_t'(6'b000000), lat, bc, res, rf, ba);
        check("post_latency", lat, 32'd11);
        check("post_result", {16'b0, res}, 32'h003F);
        check("post_flags", {26'b0, rf}, {26'b0, 6'b000011});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
